// File: rtl/adau_i2s_tx.sv
// I2S transmitter for the ADAU codec DAC path.
// Produces bclk/lrclk/sdata from a single-entry holding register fed by a
// valid/ready handshake. A frame is 64 bit clocks: left slot (lrclk=0) then
// right slot (lrclk=1), each 32 bits with a one-bit I2S delay before the MSB.
module adau_i2s_tx #(
  parameter int unsigned CLK_DIV = 4,   // bclk half-period in clk cycles (2..255)
  parameter int unsigned DATA_W  = 24   // sample width (16..31)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              valid,
  output logic              ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
  localparam logic [5:0] DataLast = 6'(DATA_W);

  logic [0:0]        state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic              bclk_q, bclk_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic [DATA_W-1:0] sr_l_q, sr_l_d;
  logic [DATA_W-1:0] sr_r_q, sr_r_d;

  logic       div_tc;
  logic       bclk_fall;
  logic       wrap;
  logic       frame_start;
  logic       go_idle;
  logic       accept;
  logic [5:0] bit_nxt;
  logic [4:0] slot;
  logic       data_bit;

  // Event decode: divider terminal count, bclk falling edge, frame boundaries.
  always_comb begin
    div_tc      = (state_q == S_RUN) && (div_q == DivLast);
    bclk_fall   = div_tc && bclk_q;
    wrap        = bclk_fall && (bit_cnt_q == 6'd63);
    // Leaving idle counts as a frame start, as does the 63->0 wrap while enabled.
    frame_start = enable && ((state_q == S_IDLE) || wrap);
    go_idle     = wrap && !enable;
    accept      = valid && !hold_full_q;
    bit_nxt     = bit_cnt_q + 6'd1;
    slot        = bit_nxt[4:0];
    // Slot bit 0 is the I2S one-bit delay; bits past DATA_W are zero padding.
    data_bit    = (slot != 5'd0) && ({1'b0, slot} <= DataLast);
  end

  // Next-state for the serializer: divider, bit clock, counters and shift registers.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    sr_l_d     = sr_l_q;
    sr_r_d     = sr_r_q;

    if (frame_start) begin
      state_d    = S_RUN;
      div_d      = 8'd0;
      bclk_d     = 1'b0;
      bit_cnt_d  = 6'd0;
      lrclk_d    = 1'b0;
      sdata_d    = 1'b0;
      sr_l_d     = hold_full_q ? hold_l_q : '0;
      sr_r_d     = hold_full_q ? hold_r_q : '0;
      underrun_d = !hold_full_q;
    end else if (go_idle) begin
      state_d   = S_IDLE;
      div_d     = 8'd0;
      bclk_d    = 1'b0;
      bit_cnt_d = 6'd0;
      lrclk_d   = 1'b1;
      sdata_d   = 1'b0;
    end else if (state_q == S_RUN) begin
      if (div_tc) begin
        div_d  = 8'd0;
        bclk_d = !bclk_q;
        // lrclk/sdata only move on the falling edge so the codec samples stable data.
        if (bclk_fall) begin
          bit_cnt_d = bit_nxt;
          lrclk_d   = bit_nxt[5];
          if (!data_bit) begin
            sdata_d = 1'b0;
          end else if (bit_nxt[5]) begin
            sdata_d = sr_r_q[DATA_W-1];
            sr_r_d  = {sr_r_q[DATA_W-2:0], 1'b0};
          end else begin
            sdata_d = sr_l_q[DATA_W-1];
            sr_l_d  = {sr_l_q[DATA_W-2:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  // Holding register: filled on handshake, drained by the frame-start copy.
  always_comb begin
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (accept) begin
      hold_l_d = left_in;
      hold_r_d = right_in;
    end
    // A copy and a new accept in the same cycle leave the register full.
    hold_full_d = accept || (hold_full_q && !frame_start);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_q       <= 8'd0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= 6'd0;
      lrclk_q     <= 1'b1;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sr_l_q      <= '0;
      sr_r_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sr_l_q      <= sr_l_d;
      sr_r_q      <= sr_r_d;
    end
  end

  // Registered outputs; ready reflects an empty holding register.
  always_comb begin
    ready    = !hold_full_q;
    bclk     = bclk_q;
    lrclk    = lrclk_q;
    sdata    = sdata_q;
    underrun = underrun_q;
  end

endmodule

// File: tb/tb_adau_i2s_tx.sv
// Bench for adau_i2s_tx: directed stimulus pushes expected sample pairs into a
// queue; a monitor decodes the I2S stream and pops/compares per frame.
module tb_adau_i2s_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DATA_W  = 24;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] left_in = '0;
  logic [DATA_W-1:0] right_in = '0;
  logic              valid = 1'b0;
  logic              ready;
  logic              bclk;
  logic              lrclk;
  logic              sdata;
  logic              underrun;

  always #5 clk = ~clk;

  adau_i2s_tx #(
    .CLK_DIV(CLK_DIV),
    .DATA_W (DATA_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .left_in (left_in),
    .right_in(right_in),
    .valid   (valid),
    .ready   (ready),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .underrun(underrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0;
  logic        bclk_prev = 1'b0;
  logic        lr_prev_mon = 1'b1;
  logic        ur_prev = 1'b0;
  int          mpos = 0;
  logic [DATA_W-1:0] word = '0;
  logic [DATA_W-1:0] got_l = '0;
  logic [DATA_W-1:0] got_r = '0;
  logic        pad_bad = 1'b0;
  int          last_rise = 0;
  int          bclk_period = 0;
  int          rise_count = 0;
  int          ur_count = 0;
  logic [47:0] exp_pair;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      lr_prev_mon = 1'b1;
      mpos        = 0;
      pad_bad     = 1'b0;
      word        = '0;
      bclk_prev   = 1'b0;
      ur_prev     = 1'b0;
    end else begin
      if (underrun) begin
        ur_count++;
        check("underrun_at_frame_start", lrclk, 1'b0);
        check("underrun_one_cycle", ur_prev, 1'b0);
      end
      ur_prev = underrun;
      if (bclk && !bclk_prev) begin
        rise_count++;
        bclk_period = cyc - last_rise;
        last_rise   = cyc;
        if (lrclk != lr_prev_mon) begin
          mpos = 0;
          if (!lrclk) pad_bad = 1'b0;
        end else begin
          mpos++;
        end
        lr_prev_mon = lrclk;
        if (mpos == 0 || mpos > DATA_W) begin
          if (sdata) pad_bad = 1'b1;
        end else begin
          word = {word[DATA_W-2:0], sdata};
        end
        if (mpos == DATA_W) begin
          if (lrclk) got_r = word;
          else       got_l = word;
        end
        if (lrclk && mpos == 31) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_unexpected: got L=%h R=%h, required no frame", got_l, got_r);
          end else begin
            exp_pair = exp_q.pop_front();
            check("frame_pair", {got_l, got_r}, exp_pair);
            check("frame_padding", pad_bad, 1'b0);
          end
        end
      end
      bclk_prev = bclk;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offer a pair and wait for the handshake; leaves valid high.
  task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int n;
    n        = 0;
    left_in  = l;
    right_in = r;
    valid    = 1'b1;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got ready=0 after %0d cycles, required ready=1", n);
    end else begin
      exp_q.push_back({l, r});
    end
    @(negedge clk);
  endtask

  // Wait for an lrclk 1->0 transition (frame start), bounded.
  task automatic wait_lr_fall(input int bound, output longint t);
    logic prev;
    logic found;
    int   n;
    prev  = lrclk;
    found = 1'b0;
    n     = 0;
    t     = 0;
    while (!found && n < bound) begin
      @(negedge clk);
      n++;
      found = prev && !lrclk;
      prev  = lrclk;
    end
    t = longint'($time);
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_start_timeout: got no lrclk fall in %0d cycles, required one", bound);
    end
  endtask

  task automatic wait_drained(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending frames, required 0", exp_q.size());
    end
  endtask

  // ---------------- directed tests ----------------
  longint t1, t2, t3;
  int     u0, rc;

  initial begin
    // Reset with enable low; outputs must sit at idle values.
    #1 reset_n = 1'b0;
    #1 check("reset_async_outputs", {bclk, lrclk, sdata, ready, underrun}, 5'b01010);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_hold_outputs", {bclk, lrclk, sdata, ready, underrun}, 5'b01010);
    end

    // Pair accepted in idle, then run: bit timing, frame length, enable drop at bit 10.
    u0 = ur_count;
    send(24'h800001, 24'h7FFFFE);
    valid = 1'b0;
    check("ready_after_accept", ready, 1'b0);
    enable = 1'b1;
    wait_lr_fall(20, t1);
    check("ready_after_copy", ready, 1'b1);
    send(24'h123456, 24'h654321);
    valid = 1'b0;
    wait_lr_fall(600, t2);
    check("frame_length", (t2 - t1) / 10, 512);
    check("bclk_period", bclk_period, 2 * CLK_DIV);
    check("no_underrun_when_fed", ur_count - u0, 0);
    repeat (80) @(negedge clk);
    enable = 1'b0;
    repeat (431) @(negedge clk);
    check("lrclk_at_bit63", lrclk, 1'b1);
    check("bclk_high_bit63", bclk, 1'b1);
    @(negedge clk);
    check("idle_after_drop", {bclk, lrclk, sdata}, 3'b010);
    rc = rise_count;
    repeat (200) @(negedge clk);
    check("idle_no_bclk", rise_count - rc, 0);
    check("idle_ready", ready, 1'b1);
    check("drained_t2", exp_q.size(), 0);

    // Enable with no samples: silent frames, one underrun each.
    u0 = ur_count;
    enable = 1'b1;
    wait_lr_fall(20, t3);
    repeat (3) exp_q.push_back(48'h0);
    repeat (1024 + 80) @(negedge clk);
    enable = 1'b0;
    repeat (460) @(negedge clk);
    check("underrun_per_frame", ur_count - u0, 3);
    check("drained_t3", exp_q.size(), 0);
    check("idle_after_underruns", {bclk, lrclk}, 2'b01);

    // valid held high with a stream of pairs: order preserved, no underrun.
    u0 = ur_count;
    send(24'h000001, 24'hFFFFFF);
    enable = 1'b1;
    send(24'h7FFFFF, 24'h800000);
    send(24'hA5A5A5, 24'h5A5A5A);
    send(24'h123456, 24'hFEDCBA);
    valid = 1'b0;
    wait_drained(4000);
    enable = 1'b0;
    repeat (600) @(negedge clk);
    check("stream_no_underrun", ur_count - u0, 0);
    check("drained_t4", exp_q.size(), 0);

    // Reset mid-frame at bit 40, then restart from bit 0.
    send(24'h111111, 24'h222222);
    valid  = 1'b0;
    enable = 1'b1;
    wait_lr_fall(20, t1);
    repeat (320) @(negedge clk);
    check("pre_reset_right_slot", lrclk, 1'b1);
    reset_n = 1'b0;
    #1 check("reset_midframe_outputs", {bclk, lrclk, sdata, ready, underrun}, 5'b01010);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(48'h0);
    @(negedge clk);
    check("restart_lrclk_bclk", {lrclk, bclk}, 2'b00);
    check("restart_underrun", underrun, 1'b1);
    repeat (79) @(negedge clk);
    enable = 1'b0;
    repeat (460) @(negedge clk);
    check("drained_t5", exp_q.size(), 0);
    check("idle_after_restart", {bclk, lrclk}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
